// File: rtl/jesd204b_pkg.sv
// Shared constants and state encoding for the JESD204B receive link layer.
package jesd204b_pkg;

  localparam logic [7:0] K_WORD = 8'hBC;
  localparam logic [7:0] R_WORD = 8'h1C;
  localparam logic [7:0] A_WORD = 8'h7C;
  localparam logic [7:0] F_WORD = 8'hFC;
  localparam logic [7:0] Q_WORD = 8'h9C;
  localparam int unsigned K_PARAM = 16;

  localparam logic [6:0] ILAS_TIMEOUT = 7'd80;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCgs  = 2'd1,
    StIlas = 2'd2,
    StData = 2'd3
  } link_state_e;

  function automatic logic is_cgs_word(logic [31:0] w, logic [3:0] k);
    return (k == 4'hF) && (w == {4{K_WORD}});
  endfunction

endpackage

// File: rtl/jesd204b_descrambler.sv
// Self-synchronizing 1+x^14+x^15 descrambler, 32 bits per clock, MSB is the oldest bit.
// Only built into the link layer when JESD_RX_DESCRAMBLER_EN is defined.
module jesd204b_descrambler (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  output logic [31:0] d_out
);

  logic [14:0] hist_q;
  logic [46:0] chain;

  // chain[i+14] / chain[i+15] are the bits received 14 / 15 positions before chain[i].
  assign chain = {hist_q, d_in};

  always_comb begin
    d_out = '0;
    for (int i = 0; i < 32; i++) begin
      d_out[i] = chain[i] ^ chain[i+14] ^ chain[i+15];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= d_in[14:0];
    end
  end

endmodule

// File: rtl/jesd204b_rx_link_layer.sv
// JESD204B receive link layer: CGS/ILAS sync FSM, frame-char restoration, I/Q output.
// Optional descrambler enabled by defining JESD_RX_DESCRAMBLER_EN.
module jesd204b_rx_link_layer
  import jesd204b_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_par_data,
  input  logic [3:0]  rx_datak,
  input  logic        scrambler_is_on,
  output logic        sync_b,
  output logic [15:0] rx_data_i,
  output logic [15:0] rx_data_q,
  output logic        rx_valid,
  output logic [7:0]  err_cnt,
  output logic [7:0]  state_out
);

  logic [31:0] w_q;
  logic [3:0]  k_q;
  link_state_e state_q, state_d;
  logic [1:0]  cgs_cnt_q, cgs_cnt_d;
  logic [2:0]  mf_cnt_q, mf_cnt_d;
  logic        in_mf_q, in_mf_d;
  logic [6:0]  ilas_cnt_q, ilas_cnt_d;
  logic        tail_q, tail_d;
  logic [7:0]  prev_q, err_q, err_d;
  logic [31:0] data_q, desc_w, restored;
  logic        valid_q, valid_d, err_inc;
  logic        cgs_word, r_start, a_end, low_fill, tail_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= '0;
      k_q <= '0;
    end else begin
      w_q <= {rx_par_data[7:0], rx_par_data[15:8], rx_par_data[23:16], rx_par_data[31:24]};
      k_q <= {rx_datak[0], rx_datak[1], rx_datak[2], rx_datak[3]};
    end
  end

`ifdef JESD_RX_DESCRAMBLER_EN
  logic [31:0] desc_out;

  jesd204b_descrambler u_descrambler (
    .clk   (clk),
    .reset (reset),
    .d_in  (w_q),
    .d_out (desc_out)
  );

  assign desc_w = scrambler_is_on ? desc_out : w_q;
`else
  logic unused_scrambler_is_on;
  assign unused_scrambler_is_on = scrambler_is_on;
  assign desc_w = w_q;
`endif

  assign cgs_word  = is_cgs_word(w_q, k_q);
  assign r_start   = k_q[3] && (w_q[31:24] == R_WORD);
  assign a_end     = k_q[0] && (w_q[7:0] == A_WORD);
  assign low_fill  = k_q[0] && ((w_q[7:0] == F_WORD) || (w_q[7:0] == A_WORD));
  assign tail_word = tail_q && (k_q == 4'b0001) && (w_q[7:0] == F_WORD);

  // Unscrambled links repeat the previous octet as the frame-end character.
  always_comb begin
    restored = desc_w;
    if (low_fill) begin
`ifdef JESD_RX_DESCRAMBLER_EN
      restored[7:0] = scrambler_is_on ? w_q[7:0] : prev_q;
`else
      restored[7:0] = prev_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cgs_cnt_d  = cgs_cnt_q;
    mf_cnt_d   = mf_cnt_q;
    in_mf_d    = in_mf_q;
    ilas_cnt_d = ilas_cnt_q;
    tail_d     = tail_q;
    err_inc    = 1'b0;
    valid_d    = 1'b0;
    sync_b     = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d   = StCgs;
        cgs_cnt_d = '0;
      end
      StCgs: begin
        cgs_cnt_d = cgs_word ? cgs_cnt_q + 2'd1 : 2'd0;
        if (cgs_word && (cgs_cnt_q == 2'd3)) begin
          state_d    = StIlas;
          cgs_cnt_d  = '0;
          mf_cnt_d   = '0;
          in_mf_d    = 1'b0;
          ilas_cnt_d = '0;
        end
      end
      StIlas: begin
        sync_b     = 1'b1;
        ilas_cnt_d = ilas_cnt_q + 7'd1;
        if (r_start) in_mf_d = 1'b1;
        if (a_end && (in_mf_q || r_start)) begin
          in_mf_d  = 1'b0;
          mf_cnt_d = mf_cnt_q + 3'd1;
        end
        if (a_end && (in_mf_q || r_start) && (mf_cnt_q == 3'd3)) begin
          state_d   = StData;
          tail_d    = 1'b1;
          cgs_cnt_d = '0;
        end else if (ilas_cnt_q == ILAS_TIMEOUT) begin
          state_d   = StCgs;
          err_inc   = 1'b1;
          cgs_cnt_d = '0;
        end
      end
      StData: begin
        sync_b    = 1'b1;
        cgs_cnt_d = cgs_word ? cgs_cnt_q + 2'd1 : 2'd0;
        tail_d    = tail_word;
        if (!tail_word) begin
          err_inc = (|k_q[3:1]) || (k_q[0] && !low_fill);
          valid_d = 1'b1;
        end
        if (cgs_word && (cgs_cnt_q == 2'd3)) begin
          state_d   = StCgs;
          valid_d   = 1'b0;
          cgs_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cgs_cnt_q  <= '0;
      mf_cnt_q   <= '0;
      in_mf_q    <= 1'b0;
      ilas_cnt_q <= '0;
      tail_q     <= 1'b0;
      err_q      <= '0;
      prev_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cgs_cnt_q  <= cgs_cnt_d;
      mf_cnt_q   <= mf_cnt_d;
      in_mf_q    <= in_mf_d;
      ilas_cnt_q <= ilas_cnt_d;
      tail_q     <= tail_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      if (valid_d) begin
        data_q <= restored;
        prev_q <= restored[7:0];
      end
    end
  end

  assign rx_data_i = data_q[31:16];
  assign rx_data_q = data_q[15:0];
  assign rx_valid  = valid_q;
  assign err_cnt   = err_q;
  assign state_out = {6'b0, state_q};

endmodule
